// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state type and the grant-index width helper used by the top
// and the priority-pick sub-module.
package wrr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_t;

    // Supported requester count range.
    localparam int WRR_N_MIN = 2;
    localparam int WRR_N_MAX = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int wrr_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_pick.sv
// Combinational round-robin priority pick.
// Returns the first requester at or after ptr (wrapping from N-1 to 0) as a
// one-hot vector, its index, and whether any request is present.
module wrr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = wrr_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    logic [N-1:0] masked_req;
    logic         found;

    // Requests at or above ptr take priority over the wrapped-around ones.
    always_comb begin
        masked_req = '0;
        for (int i = 0; i < N; i++) begin
            masked_req[i] = req[i] && (IW'(i) >= ptr);
        end
    end

    // Lowest masked request wins; otherwise the lowest unmasked one.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (masked_req[i] && !found) begin
                found       = 1'b1;
                pick_oh[i]  = 1'b1;
                pick_idx    = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found       = 1'b1;
                pick_oh[i]  = 1'b1;
                pick_idx    = IW'(i);
            end
        end
    end

    // Any request at all.
    always_comb begin
        pick_any = |req;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant.
// A granted requester keeps the grant for weight[i] acknowledged transfers
// (a weight of 0 counts as 1), then priority rotates to the next index.
// Optional feature macro: WRR_ARBITER_LOCK_EN adds a 'last' input so that
// credit counts packets rather than single transfers.
//
// state | meaning
// IDLE  | no grant outstanding, gnt all-zero
// GRANT | exactly one requester holds the grant (gnt_id)
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [N-1:0]                  req,
    input  logic [N*WW-1:0]               weight,
    input  logic                          ack,
`ifdef WRR_ARBITER_LOCK_EN
    input  logic                          last,
`endif
    output logic [N-1:0]                  gnt,
    output logic                          gnt_valid,
    output logic [wrr_idx_w(N)-1:0]       gnt_id
);

    localparam int IW = wrr_idx_w(N);

    wrr_state_t    state_q,  state_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [N-1:0]  gnt_q,    gnt_d;
    logic [IW-1:0] id_q,     id_d;

    logic [IW-1:0] ptr_inc;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [WW-1:0] w_arr [N];
    logic [WW-1:0] w_load;
    logic          ack_unit;
    logic          holder_req;

    // Only an end-of-packet ack consumes credit when packet locking is built in.
`ifdef WRR_ARBITER_LOCK_EN
    always_comb begin
        ack_unit = ack & last;
    end
`else
    always_comb begin
        ack_unit = ack;
    end
`endif

    // Unpack the per-requester weights for indexed access.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_arr[i] = weight[i*WW +: WW];
        end
    end

    // Index after the current holder, wrapping to 0; also the pick priority
    // while a grant is being handed over so the holder ranks last.
    always_comb begin
        ptr_inc  = (id_q == IW'(N-1)) ? '0 : id_q + IW'(1);
        pick_ptr = (state_q == GRANT) ? ptr_inc : ptr_q;
    end

    wrr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // Credit loaded for the new winner; zero weight still allows one transfer.
    always_comb begin
        w_load = (w_arr[pick_idx] == '0) ? WW'(1) : w_arr[pick_idx];
    end

    // Next-state, grant and credit decisions.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        gnt_d      = gnt_q;
        id_d       = id_q;
        holder_req = req[id_q];

        unique case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_oh;
                    id_d     = pick_idx;
                    credit_d = w_load;
                end
            end
            GRANT: begin
                if (ack_unit && holder_req && (credit_q > WW'(1))) begin
                    credit_d = credit_q - WW'(1);
                end else if (ack_unit) begin
                    // Hand over on the same edge; holder only wins again if alone.
                    ptr_d = ptr_inc;
                    if (enable && pick_any) begin
                        gnt_d    = pick_oh;
                        id_d     = pick_idx;
                        credit_d = w_load;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        id_d     = '0;
                        credit_d = '0;
                    end
                end else if (!holder_req) begin
                    // Holder withdrew without finishing: revoke, drop credit.
                    ptr_d    = ptr_inc;
                    state_d  = IDLE;
                    gnt_d    = '0;
                    id_d     = '0;
                    credit_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                id_d     = '0;
                credit_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
        end
    end

    // Registered outputs.
    always_comb begin
        gnt       = gnt_q;
        gnt_valid = |gnt_q;
        gnt_id    = id_q;
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            ack;
`ifdef WRR_ARBITER_LOCK_EN
    logic            last;
`endif
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;

    always #5 clk = ~clk;

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .req       (req),
        .weight    (weight),
        .ack       (ack),
`ifdef WRR_ARBITER_LOCK_EN
        .last      (last),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who holds the grant (-1 = nobody), rotation start, credits left.
    int m_hold = -1;
    int m_ptr  = 0;
    int m_cred = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int scan_from(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int credits_of(input int i);
        int v;
        v = int'(weight[i*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step(input bit l);
        bit done;
        int nxt;
`ifdef WRR_ARBITER_LOCK_EN
        done = ack && l;
`else
        done = ack;
`endif
        if (!reset_n) begin
            m_hold = -1; m_ptr = 0; m_cred = 0;
        end else if (m_hold < 0) begin
            nxt = scan_from(m_ptr, req);
            if (enable && nxt >= 0) begin
                m_hold = nxt; m_cred = credits_of(nxt);
            end
        end else if (done && req[m_hold] && m_cred > 1) begin
            m_cred = m_cred - 1;
        end else if (done || !req[m_hold]) begin
            m_ptr = (m_hold + 1) % N;
            nxt = scan_from(m_ptr, req);
            if (done && enable && nxt >= 0) begin
                m_hold = nxt; m_cred = credits_of(nxt);
            end else begin
                m_hold = -1; m_cred = 0;
            end
        end
    endtask

    task automatic cyc(input bit rn, input bit en, input bit a, input bit l, input logic [N-1:0] r);
        logic [N-1:0] eg;
        reset_n = rn; enable = en; ack = a; req = r;
`ifdef WRR_ARBITER_LOCK_EN
        last = l;
`endif
        model_step(l);
        @(posedge clk);
        #1;
        eg = (m_hold < 0) ? '0 : (N'(1) << m_hold);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_hold >= 0));
        chk("gnt_id", 32'(gnt_id), (m_hold < 0) ? 32'd0 : 32'(m_hold));
    endtask

    logic [N-1:0] exp31 [5];
    int           exp32 [8];
    logic [N-1:0] r_rand;

    initial begin
        reset_n = 1'b0; enable = 1'b0; ack = 1'b0; req = '0;
        weight  = 16'h1111;
`ifdef WRR_ARBITER_LOCK_EN
        last = 1'b0;
`endif
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(0, 1, 1, 1, 4'b1111);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_id", 32'(gnt_id), 32'd0);

        // Equal weights, everyone requesting, ack every cycle: rotation without bubbles.
        exp31 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cyc(0, 0, 0, 0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 1, 1, 4'b1111);
            chk("rr_seq", 32'(gnt), 32'(exp31[k]));
        end

        // Weight 3 on requester 0, weight 1 on requester 1.
        exp32 = '{0, 0, 0, 1, 0, 0, 0, 1};
        weight = 16'h0013;
        cyc(0, 0, 0, 0, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 1, 1, 1, 4'b0011);
            chk("wrr_seq", 32'(gnt_id), 32'(exp32[k]));
        end

        // Revocation on request drop, then rotation resumes after the dropper.
        weight = 16'h1111;
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(1, 1, 0, 0, 4'b0100);
        chk("rev_grant", 32'(gnt), 32'b0100);
        cyc(1, 1, 0, 0, 4'b0000);
        chk("rev_drop", 32'(gnt), 32'd0);
        cyc(1, 1, 0, 0, 4'b1111);
        chk("rev_next", 32'(gnt), 32'b1000);

        // Enable low while granted: grant runs to ack, then idle.
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(1, 1, 0, 0, 4'b0010);
        chk("en_grant", 32'(gnt), 32'b0010);
        cyc(1, 0, 0, 0, 4'b1111);
        cyc(1, 0, 0, 0, 4'b1111);
        chk("en_hold", 32'(gnt), 32'b0010);
        cyc(1, 0, 1, 1, 4'b1111);
        chk("en_idle", 32'(gnt), 32'd0);
        cyc(1, 1, 0, 0, 4'b1111);
        chk("en_resume", 32'(gnt), 32'b0100);

        // Reset in the middle of a grant.
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(1, 1, 0, 0, 4'b1111);
        cyc(1, 1, 0, 0, 4'b1111);
        cyc(0, 1, 0, 0, 4'b1111);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_id", 32'(gnt_id), 32'd0);
        cyc(1, 1, 0, 0, 4'b1010);
        chk("post_rst", 32'(gnt), 32'b0010);

        // Zero weight behaves as one transfer.
        weight = 16'h0000;
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(1, 1, 1, 1, 4'b0011);
        cyc(1, 1, 1, 1, 4'b0011);
        chk("zero_w", 32'(gnt), 32'b0010);

`ifdef WRR_ARBITER_LOCK_EN
        // Packet locking: only an ack with last releases the grant.
        weight = 16'h1111;
        cyc(0, 0, 0, 0, 4'b0000);
        cyc(1, 1, 0, 0, 4'b0011);
        cyc(1, 1, 1, 0, 4'b0011);
        chk("lock_a0", 32'(gnt), 32'b0001);
        cyc(1, 1, 1, 0, 4'b0011);
        chk("lock_a1", 32'(gnt), 32'b0001);
        cyc(1, 1, 1, 1, 4'b0011);
        chk("lock_a2", 32'(gnt), 32'b0010);
`endif

        // Randomized traffic against the model.
        r_rand = 4'b1111;
        weight = 16'h2131;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom);
            if ($urandom_range(0, 49) == 0) weight = 16'($urandom);
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, r_rand);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
